// File: rtl/div_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : div_operand_loader
//  Description : Byte-stream front end for the fast divider. Assembles each
//                2*BYTES-byte frame into a little-endian dividend/divisor
//                pair and offers it to the divider over a valid/ready
//                handshake. Short and long frames are dropped, pulsed on
//                frame_err and tallied in a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_operand_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_dividend,
    output logic [WIDTH-1:0] op_divisor,
    output logic             frame_err,
    output logic [7:0]       err_count
);

    // Bytes per operand and width of the byte index (at least one bit).
    localparam int c_BYTES = WIDTH / 8;
    localparam int c_IDXW  = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_BYTES - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);
    localparam logic [7:0]        c_ERR_MAX  = 8'hFF;

    localparam logic [1:0] c_COLLECT_A = 2'd0;
    localparam logic [1:0] c_COLLECT_B = 2'd1;
    localparam logic [1:0] c_HOLD      = 2'd2;
    localparam logic [1:0] c_DISCARD   = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDXW-1:0]  r_idx;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_frame_err;
    logic [7:0]         r_err_count;

    logic               w_accept;
    logic               w_idx_last;
    logic               w_short_a;
    logic               w_short_b;
    logic               w_long_b;
    logic               w_err_event;
    logic [c_BYTES-1:0] w_lane_sel;

    // Per-byte lane select decoded from the running byte index.
    generate
        for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_lane
            assign w_lane_sel[gi] = (r_idx == c_IDXW'(gi));
        end
    endgenerate

    // Handshake qualification and framing-error classification.
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_idx_last  = (r_idx == c_LAST_IDX);
        // in_last anywhere in the dividend is always too early.
        w_short_a   = w_accept && (r_state == c_COLLECT_A) && in_last;
        w_short_b   = w_accept && (r_state == c_COLLECT_B) && in_last && !w_idx_last;
        w_long_b    = w_accept && (r_state == c_COLLECT_B) && !in_last && w_idx_last;
        w_err_event = w_short_a || w_short_b || w_long_b;
    end

    // Frame state machine: byte index, state and operand assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_COLLECT_A;
            r_idx      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
        end else begin
            case (r_state)
                c_COLLECT_A: begin
                    if (w_accept) begin
                        for (int b = 0; b < c_BYTES; b++) begin
                            if (w_lane_sel[b]) r_dividend[b*8 +: 8] <= in_data;
                        end
                        if (in_last) begin
                            r_state <= c_COLLECT_A;
                            r_idx   <= '0;
                        end else if (w_idx_last) begin
                            r_state <= c_COLLECT_B;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                c_COLLECT_B: begin
                    if (w_accept) begin
                        for (int b = 0; b < c_BYTES; b++) begin
                            if (w_lane_sel[b]) r_divisor[b*8 +: 8] <= in_data;
                        end
                        if (w_idx_last) begin
                            // Either a complete frame or the start of an overrun.
                            r_state <= in_last ? c_HOLD : c_DISCARD;
                            r_idx   <= '0;
                        end else if (in_last) begin
                            r_state <= c_COLLECT_A;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                c_HOLD: begin
                    if (op_ready) begin
                        r_state <= c_COLLECT_A;
                        r_idx   <= '0;
                    end
                end
                c_DISCARD: begin
                    if (w_accept && in_last) begin
                        r_state <= c_COLLECT_A;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= c_COLLECT_A;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // One-cycle error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_err <= w_err_event;
            if (w_err_event && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Bytes are refused during reset and while a pair waits for the divider.
    assign in_ready    = !rst && (r_state != c_HOLD);
    assign op_valid    = (r_state == c_HOLD);
    assign op_dividend = r_dividend;
    assign op_divisor  = r_divisor;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_div_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_operand_loader
//  Description : Directed self-checking bench for div_operand_loader with a
//                32-bit instance and an 8-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 32-bit instance signals
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data  = 8'h00;
    logic        in_last  = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_dividend;
    logic [31:0] op_divisor;
    logic        frame_err;
    logic [7:0]  err_count;

    // 8-bit instance signals
    logic        in_valid_8 = 1'b0;
    logic        in_ready_8;
    logic [7:0]  in_data_8  = 8'h00;
    logic        in_last_8  = 1'b0;
    logic        op_valid_8;
    logic        op_ready_8 = 1'b0;
    logic [7:0]  op_dividend_8;
    logic [7:0]  op_divisor_8;
    logic        frame_err_8;
    logic [7:0]  err_count_8;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    div_operand_loader #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_dividend(op_dividend), .op_divisor(op_divisor),
        .frame_err(frame_err), .err_count(err_count)
    );

    div_operand_loader #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_data(in_data_8), .in_last(in_last_8),
        .op_valid(op_valid_8), .op_ready(op_ready_8),
        .op_dividend(op_dividend_8), .op_divisor(op_divisor_8),
        .frame_err(frame_err_8), .err_count(err_count_8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte at a negedge, let it be accepted, return at the next negedge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_byte_8(input logic [7:0] d, input logic l);
        int n;
        in_valid_8 = 1'b1; in_data_8 = d; in_last_8 = l;
        n = 0;
        while (!in_ready_8 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready_8) chk("accept8_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_8 = 1'b0; in_last_8 = 1'b0;
    endtask

    // Good 8-byte frame base..base+7 with op_ready held high.
    task automatic good_frame(input string tag, input logic [7:0] base);
        logic [7:0] b;
        logic [31:0] exp_a, exp_b;
        op_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = base + 8'(i);
            send_byte(b, i == 7);
            if (i < 4) exp_a[i*8 +: 8] = b;
            else       exp_b[(i-4)*8 +: 8] = b;
        end
        chk({tag, "_valid"},    {31'd0, op_valid}, 32'd1);
        chk({tag, "_dividend"}, op_dividend, exp_a);
        chk({tag, "_divisor"},  op_divisor,  exp_b);
        chk({tag, "_noerr"},    {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        chk({tag, "_vdrop"},    {31'd0, op_valid}, 32'd0);
        chk({tag, "_rdy"},      {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready},  32'd0);
        chk("rst_op_valid", {31'd0, op_valid},  32'd0);
        chk("rst_dividend", op_dividend,        32'd0);
        chk("rst_divisor",  op_divisor,         32'd0);
        chk("rst_err",      {31'd0, frame_err}, 32'd0);
        chk("rst_cnt",      {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", {31'd0, in_ready},  32'd1);

        // Basic frame, op_ready high
        good_frame("basic", 8'h10);

        // Back-pressure: op_ready low for 5 cycles
        op_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), i == 7);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid",    {31'd0, op_valid}, 32'd1);
            chk("bp_rdy",      {31'd0, in_ready}, 32'd0);
            chk("bp_dividend", op_dividend, 32'h63626160);
            chk("bp_divisor",  op_divisor,  32'h67666564);
            @(negedge clk);
        end
        op_ready = 1'b1;
        @(negedge clk);
        chk("bp_vdrop", {31'd0, op_valid}, 32'd0);
        chk("bp_rdy2",  {31'd0, in_ready}, 32'd1);

        // Short frame: 5 bytes
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hA0 + 8'(i), i == 4);
            chk("short_err", {31'd0, frame_err}, (i == 4) ? 32'd1 : 32'd0);
            chk("short_nov", {31'd0, op_valid},  32'd0);
        end
        exp_errs++;
        chk("short_cnt", {24'd0, err_count}, 32'(exp_errs));
        @(negedge clk);
        chk("short_pulse_end", {31'd0, frame_err}, 32'd0);
        good_frame("after_short", 8'h20);

        // Long frame: 10 bytes
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h30 + 8'(i), i == 9);
            chk("long_err", {31'd0, frame_err}, (i == 7) ? 32'd1 : 32'd0);
            chk("long_nov", {31'd0, op_valid},  32'd0);
            if (i == 7) exp_errs++;
        end
        chk("long_cnt", {24'd0, err_count}, 32'(exp_errs));
        good_frame("after_long", 8'h40);
        chk("long_cnt2", {24'd0, err_count}, 32'(exp_errs));

        // Reset mid-frame after 6 bytes
        for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy",      {31'd0, in_ready},  32'd0);
        chk("mrst_valid",    {31'd0, op_valid},  32'd0);
        chk("mrst_err",      {31'd0, frame_err}, 32'd0);
        chk("mrst_cnt",      {24'd0, err_count}, 32'd0);
        chk("mrst_dividend", op_dividend,        32'd0);
        chk("mrst_divisor",  op_divisor,         32'd0);
        rst = 1'b0;
        exp_errs = 0;
        @(negedge clk);
        chk("mrst_err2", {31'd0, frame_err}, 32'd0);
        good_frame("after_rst", 8'h50);

        // 256 one-byte frames: pulse every time, counter saturates
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 1'b1);
            if (exp_errs < 255) exp_errs++;
            chk("sat_pulse", {31'd0, frame_err}, 32'd1);
            chk("sat_cnt",   {24'd0, err_count}, 32'(exp_errs));
        end
        @(negedge clk);
        chk("sat_hold", {24'd0, err_count}, 32'd255);

        // WIDTH=8 instance: zero divisor is forwarded
        op_ready_8 = 1'b1;
        send_byte_8(8'hAB, 1'b0);
        chk("w8_mid_nov", {31'd0, op_valid_8}, 32'd0);
        send_byte_8(8'h00, 1'b1);
        chk("w8_valid",    {31'd0, op_valid_8},    32'd1);
        chk("w8_dividend", {24'd0, op_dividend_8}, 32'h000000AB);
        chk("w8_divisor",  {24'd0, op_divisor_8},  32'h00000000);
        chk("w8_noerr",    {31'd0, frame_err_8},   32'd0);
        @(negedge clk);
        chk("w8_vdrop",    {31'd0, op_valid_8},    32'd0);
        // WIDTH=8 short frame: single byte with in_last
        send_byte_8(8'h11, 1'b1);
        chk("w8_short_err", {31'd0, frame_err_8},  32'd1);
        chk("w8_short_cnt", {24'd0, err_count_8},  32'd1);
        chk("w8_short_nov", {31'd0, op_valid_8},   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
